// File: rtl/fetch_queue_if.sv
// Decode-side handshake of the fetch queue: FETCH_WIDTH output lanes plus a
// single ready that pops every valid lane at once.
interface fetch_queue_if #(
  parameter int FETCH_WIDTH = 2
) ();
  logic [FETCH_WIDTH-1:0]    out_valid;
  logic [FETCH_WIDTH*32-1:0] out_instr;
  logic [FETCH_WIDTH*32-1:0] out_pc;
  logic                      deq_ready;

  modport master (output out_valid, out_instr, out_pc, input deq_ready);
  modport slave  (input out_valid, out_instr, out_pc, output deq_ready);
endinterface

// File: rtl/fetch_queue.sv
// Multi-wide sequential fetch from a flat ROM into a circular instruction queue,
// presenting the oldest FETCH_WIDTH entries to Decode; redirect flushes everything.
module fetch_queue #(
  parameter int ROM_WORDS   = 256,
  parameter int FETCH_WIDTH = 2,
  parameter int QUEUE_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [ROM_WORDS*32-1:0]          instr_rom,
  input  logic [31:0]                      rom_size,
  input  logic                             redirect_valid,
  input  logic [31:0]                      redirect_pc,
  fetch_queue_if.master                    decode,
  output logic [31:0]                      pc,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] occupancy,
  output logic                             fetch_complete
);
  localparam int PTR_W     = $clog2(QUEUE_DEPTH);
  localparam int OCC_W     = $clog2(QUEUE_DEPTH+1);
  localparam int ROM_IDX_W = $clog2(ROM_WORDS);

  typedef enum logic [1:0] {FETCH, DRAIN, DONE} state_t;

  state_t             state;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [31:0]        q_instr [QUEUE_DEPTH];
  logic [31:0]        q_pc    [QUEUE_DEPTH];
  logic [31:0]        rom_word [ROM_WORDS];

  logic [31:0]            lane_addr [FETCH_WIDTH];
  logic [31:0]            lane_word [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] lane_we;
  logic [OCC_W-1:0]       n_wr;
  logic [OCC_W-1:0]       wr_cnt;
  logic [OCC_W-1:0]       n_pop;
  logic                   enq;

  wire unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

  for (genvar w = 0; w < ROM_WORDS; w++) begin : g_rom
    assign rom_word[w] = instr_rom[w*32 +: 32];
  end

  // Fetch lanes: contiguous run of addresses below rom_size, limited by free space
  always_comb begin
    n_wr    = '0;
    lane_we = '0;
    enq     = (state == FETCH) && !redirect_valid &&
              (occupancy <= OCC_W'(QUEUE_DEPTH - FETCH_WIDTH));
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      lane_addr[k] = pc + 32'(4*k);
      lane_word[k] = '0;
      if (lane_addr[k][31:2] < 30'(ROM_WORDS))
        lane_word[k] = rom_word[lane_addr[k][2 +: ROM_IDX_W]];
      // 33-bit compare so a lane near the top of the address space cannot wrap
      if ((({1'b0, pc} + 33'(4*k)) < {1'b0, rom_size}) && (n_wr == OCC_W'(k)))
        n_wr = OCC_W'(k + 1);
    end
    for (int k = 0; k < FETCH_WIDTH; k++)
      lane_we[k] = enq && (OCC_W'(k) < n_wr);
    wr_cnt = enq ? n_wr : '0;
  end

  always_comb begin
    n_pop = '0;
    if (decode.deq_ready && !redirect_valid)
      n_pop = (occupancy < OCC_W'(FETCH_WIDTH)) ? occupancy : OCC_W'(FETCH_WIDTH);
  end

  // Control state: pointers, occupancy, pc and the fetch FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= FETCH;
      pc             <= '0;
      head           <= '0;
      tail           <= '0;
      occupancy      <= '0;
      fetch_complete <= 1'b0;
    end else if (redirect_valid) begin
      state          <= FETCH;
      pc             <= {redirect_pc[31:2], 2'b00};
      head           <= '0;
      tail           <= '0;
      occupancy      <= '0;
      fetch_complete <= 1'b0;
    end else begin
      head      <= head + PTR_W'(n_pop);
      tail      <= tail + PTR_W'(wr_cnt);
      occupancy <= occupancy + wr_cnt - n_pop;
      pc        <= pc + (32'(wr_cnt) << 2);
      case (state)
        FETCH: if (pc >= rom_size) state <= DRAIN;
        DRAIN: if (occupancy == '0) begin
          state          <= DONE;
          fetch_complete <= 1'b1;
        end
        default: state <= DONE;
      endcase
    end
  end

  // Queue storage: data only, validity is tracked by occupancy
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (lane_we[k]) begin
        q_instr[tail + PTR_W'(k)] <= lane_word[k];
        q_pc[tail + PTR_W'(k)]    <= lane_addr[k];
      end
    end
  end

  always_comb begin
    decode.out_valid = '0;
    decode.out_instr = '0;
    decode.out_pc    = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (occupancy > OCC_W'(i)) begin
        decode.out_valid[i]          = 1'b1;
        decode.out_instr[i*32 +: 32] = q_instr[head + PTR_W'(i)];
        decode.out_pc[i*32 +: 32]    = q_pc[head + PTR_W'(i)];
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: FETCH_WIDTH=2 and =3 instances share stimulus and are
// each compared against a queue-based reference model every cycle.
module tb_fetch_queue;
  localparam int RW = 256;
  localparam int S_FETCH = 0, S_DRAIN = 1, S_DONE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic [RW*32-1:0] instr_rom;
  logic [31:0]     rom_size;
  logic            redirect_valid;
  logic [31:0]     redirect_pc;
  logic            deq;
  logic [31:0]     pc2, pc3;
  logic [3:0]      occ2, occ3;
  logic            fc2, fc3;

  fetch_queue_if #(.FETCH_WIDTH(2)) if2 ();
  fetch_queue_if #(.FETCH_WIDTH(3)) if3 ();
  assign if2.deq_ready = deq;
  assign if3.deq_ready = deq;

  fetch_queue #(.ROM_WORDS(RW), .FETCH_WIDTH(2), .QUEUE_DEPTH(8)) dut2 (
    .clk(clk), .reset_n(reset_n), .instr_rom(instr_rom), .rom_size(rom_size),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .decode(if2),
    .pc(pc2), .occupancy(occ2), .fetch_complete(fc2));

  fetch_queue #(.ROM_WORDS(RW), .FETCH_WIDTH(3), .QUEUE_DEPTH(8)) dut3 (
    .clk(clk), .reset_n(reset_n), .instr_rom(instr_rom), .rom_size(rom_size),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .decode(if3),
    .pc(pc3), .occupancy(occ3), .fetch_complete(fc3));

  logic [31:0] rom_mem [RW];
  int errors = 0;
  int checks = 0;

  typedef struct packed { logic [31:0] instr; logic [31:0] addr; } ent_t;
  ent_t        mq [2][$];
  logic [31:0] m_pc [2];
  int          m_st [2];

  function automatic logic [31:0] rom_at(input longint a);
    longint idx = a >> 2;
    return (idx < RW) ? rom_mem[idx] : 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete();
      m_pc[d] = 32'd0;
      m_st[d] = S_FETCH;
    end
  endtask

  // One clock edge of behaviour, from the inputs that were present at the edge
  task automatic model_step();
    int fw, occ0, popn, wr;
    logic [31:0] pc0;
    longint a;
    ent_t e;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      fw = d + 2;
      occ0 = mq[d].size();
      pc0 = m_pc[d];
      if (redirect_valid) begin
        mq[d].delete();
        m_pc[d] = {redirect_pc[31:2], 2'b00};
        m_st[d] = S_FETCH;
      end else begin
        popn = deq ? ((occ0 < fw) ? occ0 : fw) : 0;
        repeat (popn) void'(mq[d].pop_front());
        wr = 0;
        if (m_st[d] == S_FETCH && (8 - occ0) >= fw) begin
          for (int k = 0; k < fw; k++) begin
            a = longint'(pc0) + 4 * k;
            if (a >= longint'(rom_size)) break;
            e.instr = rom_at(a);
            e.addr = a[31:0];
            mq[d].push_back(e);
            wr++;
          end
        end
        m_pc[d] = pc0 + 32'(4 * wr);
        if (m_st[d] == S_FETCH && pc0 >= rom_size) m_st[d] = S_DRAIN;
        else if (m_st[d] == S_DRAIN && occ0 == 0) m_st[d] = S_DONE;
      end
    end
  endtask

  task automatic compare_dut(input int d);
    int fw;
    logic [3:0] gv, ev;
    logic [127:0] gi, gp;
    logic [31:0] ei, ep;
    fw = d + 2;
    if (d == 0) begin
      gv = {2'b00, if2.out_valid}; gi = {64'd0, if2.out_instr}; gp = {64'd0, if2.out_pc};
    end else begin
      gv = {1'b0, if3.out_valid}; gi = {32'd0, if3.out_instr}; gp = {32'd0, if3.out_pc};
    end
    ev = '0;
    for (int i = 0; i < fw; i++) begin
      ei = '0; ep = '0;
      if (i < mq[d].size()) begin
        ev[i] = 1'b1; ei = mq[d][i].instr; ep = mq[d][i].addr;
      end
      check($sformatf("fw%0d lane%0d instr", fw, i), gi[i*32 +: 32], ei);
      check($sformatf("fw%0d lane%0d pc", fw, i), gp[i*32 +: 32], ep);
    end
    check($sformatf("fw%0d out_valid", fw), 32'(gv), 32'(ev));
    check($sformatf("fw%0d pc", fw), (d == 0) ? pc2 : pc3, m_pc[d]);
    check($sformatf("fw%0d occupancy", fw), 32'((d == 0) ? occ2 : occ3), 32'(mq[d].size()));
    check($sformatf("fw%0d fetch_complete", fw), 32'((d == 0) ? fc2 : fc3), 32'(m_st[d] == S_DONE));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    compare_dut(0);
    compare_dut(1);
  endtask

  typedef struct {
    logic rst; logic [31:0] rsz; logic redir; logic [31:0] rpc; logic dq;
    logic [1:0] e_valid; logic [31:0] e_pc0; logic [31:0] e_pc; logic [3:0] e_occ; logic e_fc;
  } vec_t;
  vec_t tbl [$];

  function automatic vec_t mk(input logic rst, input logic [31:0] rsz, input logic redir,
      input logic [31:0] rpc, input logic dq, input logic [1:0] ev, input logic [31:0] epc0,
      input logic [31:0] epc, input logic [3:0] eocc, input logic efc);
    vec_t v;
    v.rst = rst; v.rsz = rsz; v.redir = redir; v.rpc = rpc; v.dq = dq;
    v.e_valid = ev; v.e_pc0 = epc0; v.e_pc = epc; v.e_occ = eocc; v.e_fc = efc;
    return v;
  endfunction

  int emitted [2];
  logic [31:0] exp_next [2];

  initial begin
    for (int k = 0; k < RW; k++) begin
      rom_mem[k] = $urandom | 32'h1;
      instr_rom[k*32 +: 32] = rom_mem[k];
    end
    reset_n = 1'b0; rom_size = 32'd12; redirect_valid = 1'b0; redirect_pc = '0; deq = 1'b1;
    model_reset();

    // Short program of three words, drained and completed
    tbl.push_back(mk(0, 12, 0, 0, 1, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 12, 0, 0, 1, 2'b11, 0, 8, 2, 0));
    tbl.push_back(mk(1, 12, 0, 0, 1, 2'b01, 8, 12, 1, 0));
    tbl.push_back(mk(1, 12, 0, 0, 1, 2'b00, 0, 12, 0, 0));
    tbl.push_back(mk(1, 12, 0, 0, 1, 2'b00, 0, 12, 0, 1));
    tbl.push_back(mk(1, 12, 0, 0, 1, 2'b00, 0, 12, 0, 1));
    // Back-pressure fills to 8 and stalls pc, then redirect at 6 entries
    tbl.push_back(mk(0, 160, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 160, 0, 0, 0, 2'b11, 0, 32'h08, 2, 0));
    tbl.push_back(mk(1, 160, 0, 0, 0, 2'b11, 0, 32'h10, 4, 0));
    tbl.push_back(mk(1, 160, 0, 0, 0, 2'b11, 0, 32'h18, 6, 0));
    tbl.push_back(mk(1, 160, 0, 0, 0, 2'b11, 0, 32'h20, 8, 0));
    tbl.push_back(mk(1, 160, 0, 0, 0, 2'b11, 0, 32'h20, 8, 0));
    tbl.push_back(mk(1, 160, 0, 0, 1, 2'b11, 8, 32'h20, 6, 0));
    tbl.push_back(mk(1, 160, 1, 32'h13, 1, 2'b00, 0, 32'h10, 0, 0));
    tbl.push_back(mk(1, 160, 0, 0, 0, 2'b11, 32'h10, 32'h18, 2, 0));
    // Empty program completes, redirect restarts a two-word program
    tbl.push_back(mk(0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 2'b00, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8, 1, 0, 1, 2'b00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8, 0, 0, 1, 2'b11, 0, 8, 2, 0));
    tbl.push_back(mk(1, 8, 0, 0, 1, 2'b00, 0, 8, 0, 0));
    tbl.push_back(mk(1, 8, 0, 0, 1, 2'b00, 0, 8, 0, 1));

    foreach (tbl[r]) begin
      reset_n = tbl[r].rst; rom_size = tbl[r].rsz; redirect_valid = tbl[r].redir;
      redirect_pc = tbl[r].rpc; deq = tbl[r].dq;
      step();
      check($sformatf("row%0d valid", r), 32'(if2.out_valid), 32'(tbl[r].e_valid));
      check($sformatf("row%0d pc", r), pc2, tbl[r].e_pc);
      check($sformatf("row%0d occupancy", r), 32'(occ2), 32'(tbl[r].e_occ));
      check($sformatf("row%0d fetch_complete", r), 32'(fc2), 32'(tbl[r].e_fc));
      check($sformatf("row%0d lane0 pc", r), if2.out_pc[31:0], tbl[r].e_valid[0] ? tbl[r].e_pc0 : 32'd0);
      check($sformatf("row%0d lane0 instr", r), if2.out_instr[31:0],
            tbl[r].e_valid[0] ? rom_mem[tbl[r].e_pc0[9:2]] : 32'd0);
      check($sformatf("row%0d lane1 pc", r), if2.out_pc[63:32],
            tbl[r].e_valid[1] ? tbl[r].e_pc0 + 32'd4 : 32'd0);
    end

    // Asynchronous reset in the middle of a cycle with five entries queued
    redirect_valid = 1'b0; deq = 1'b0; rom_size = 32'd20; reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (3) step();
    check("pre-reset occupancy", 32'(occ2), 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async reset valid", 32'(if2.out_valid), 32'd0);
    check("async reset occupancy", 32'(occ2), 32'd0);
    check("async reset pc", pc2, 32'd0);
    check("async reset fetch_complete", 32'(fc2), 32'd0);
    compare_dut(0);
    compare_dut(1);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("restart lane0 instr", if2.out_instr[31:0], rom_mem[0]);
    check("restart lane0 pc", if2.out_pc[31:0], 32'd0);

    // 100-word program under random back-pressure: every word once, in order
    reset_n = 1'b0; rom_size = 32'd400; deq = 1'b0;
    step();
    reset_n = 1'b1;
    emitted = '{0, 0};
    exp_next = '{32'd0, 32'd0};
    for (int c = 0; c < 700; c++) begin
      deq = 1'($urandom_range(0, 1));
      if (deq) begin
        for (int i = 0; i < 2; i++)
          if (if2.out_valid[i]) begin
            check("fw2 emit order", if2.out_pc[i*32 +: 32], exp_next[0]);
            exp_next[0] += 4; emitted[0]++;
          end
        for (int i = 0; i < 3; i++)
          if (if3.out_valid[i]) begin
            check("fw3 emit order", if3.out_pc[i*32 +: 32], exp_next[1]);
            exp_next[1] += 4; emitted[1]++;
          end
      end
      step();
    end
    check("fw2 words emitted", 32'(emitted[0]), 32'd100);
    check("fw3 words emitted", 32'(emitted[1]), 32'd100);
    check("fw2 done after drain", 32'(fc2), 32'd1);
    check("fw3 done after drain", 32'(fc3), 32'd1);

    // Random redirects, rom_size changes and ROM-overrun addresses
    for (int c = 0; c < 600; c++) begin
      deq = 1'($urandom_range(0, 1));
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom_range(0, 1400);
      if ($urandom_range(0, 29) == 0)
        case ($urandom_range(0, 4))
          0: rom_size = 32'd0;
          1: rom_size = 32'd8;
          2: rom_size = 32'd100;
          3: rom_size = 32'd400;
          default: rom_size = 32'd1200;
        endcase
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
